// File: rtl/serial_frame_unpacker_pkg.sv
// Shared types and default geometry for the serial frame unpacker.
// The optional parity output is enabled with the SER_XFER_PARITY_EN macro.
package ser_xfer_pkg;

   localparam int FRAME_W_DEF = 80;
   localparam int WORD_W_DEF  = 24;

   function automatic int ceil_div(input int num, input int den);
      return (num + den - 1) / den;
   endfunction

   localparam int WORDS_PER_FRAME = ceil_div(FRAME_W_DEF, WORD_W_DEF);
   localparam int BIT_CNT_W       = $clog2(WORD_W_DEF);
   localparam int FRAME_CNT_W     = $clog2(FRAME_W_DEF);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SHIFT,
      PAD,
      VALID,
      DONE
   } state_t;

endpackage

// File: rtl/serial_frame_unpacker_mod_counter.sv
// Modulo-MOD up counter with synchronous clear and a terminal-count flag.
module mod_counter #(
   parameter int MOD = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tc
);

   localparam int W = (MOD > 1) ? $clog2(MOD) : 1;

   logic [W-1:0] cnt_q, cnt_d;

   assign tc = (cnt_q == W'(MOD - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (clr)
         cnt_d = '0;
      else if (en)
         cnt_d = tc ? '0 : cnt_q + W'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/serial_frame_unpacker.sv
// Steers a frame register's serial output into a word register, one word at a time.
// Define SER_XFER_PARITY_EN to add the per-word even-parity output word_parity.
module serial_frame_unpacker
   import ser_xfer_pkg::*;
#(
   parameter int FRAME_W = FRAME_W_DEF,
   parameter int WORD_W  = WORD_W_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   output logic frame_load,
   output logic frame_shift,
   input  logic frame_bit,
   output logic word_shift,
   output logic word_bit,
   output logic word_valid,
   input  logic word_ready,
   output logic word_last,
   output logic busy,
`ifdef SER_XFER_PARITY_EN
   output logic word_parity,
`endif
   output logic done
);

   state_t state_q, state_d;
   logic   frame_end_q, frame_end_d;
   logic   bit_tc, frame_tc;
   logic   bit_clr, bit_en;
   logic   accept;

   assign accept  = (state_q == VALID) && word_ready;
   assign bit_clr = (state_q == LOAD) || accept;
   assign bit_en  = (state_q == SHIFT) || (state_q == PAD);

   mod_counter #(.MOD(WORD_W)) u_bit_cnt (
      .clk (clk),
      .rst (rst),
      .clr (bit_clr),
      .en  (bit_en),
      .tc  (bit_tc)
   );

   mod_counter #(.MOD(FRAME_W)) u_frame_cnt (
      .clk (clk),
      .rst (rst),
      .clr (state_q == LOAD),
      .en  (state_q == SHIFT),
      .tc  (frame_tc)
   );

   // frame_cnt wraps to 0 after its last bit, so remember that the frame ran out
   always_comb begin
      state_d     = state_q;
      frame_end_d = frame_end_q;
      case (state_q)
         IDLE:  if (start) state_d = LOAD;
         LOAD: begin
            frame_end_d = 1'b0;
            state_d     = SHIFT;
         end
         SHIFT: begin
            if (frame_tc) frame_end_d = 1'b1;
            if (bit_tc)
               state_d = VALID;
            else if (frame_tc)
               state_d = PAD;
         end
         PAD:   if (bit_tc) state_d = VALID;
         VALID: if (word_ready) state_d = frame_end_q ? DONE : SHIFT;
         DONE:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         frame_end_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         frame_end_q <= frame_end_d;
      end
   end

   assign frame_load  = (state_q == LOAD);
   assign frame_shift = (state_q == SHIFT);
   assign word_shift  = bit_en;
   assign word_bit    = (state_q == SHIFT) && frame_bit;
   assign word_valid  = (state_q == VALID);
   assign word_last   = (state_q == VALID) && frame_end_q;
   assign busy        = (state_q != IDLE);
   assign done        = (state_q == DONE);

`ifdef SER_XFER_PARITY_EN
   logic parity_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         parity_q <= 1'b0;
      else if (bit_clr)
         parity_q <= 1'b0;
      else if (bit_en)
         parity_q <= parity_q ^ word_bit;
   end

   assign word_parity = word_valid && parity_q;
`endif

endmodule

// File: tb/tb_serial_frame_unpacker.sv
// Scoreboard bench: models the frame and word shift registers around the unpacker.
module tb_serial_frame_unpacker;
   import ser_xfer_pkg::*;

   localparam int FW  = FRAME_W_DEF;
   localparam int WW  = WORD_W_DEF;
   localparam int NW  = WORDS_PER_FRAME;
   localparam int FW2 = 48;

   typedef struct packed {
      logic [WW-1:0] w;
      logic          last;
      logic          par;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic start = 1'b0;
   logic word_ready = 1'b0;
   logic frame_load, frame_shift, frame_bit, word_shift, word_bit;
   logic word_valid, word_last, busy, done;
`ifdef SER_XFER_PARITY_EN
   logic word_parity;
`endif
   logic [FW-1:0] frame_data = '0;
   logic [FW-1:0] frame_reg_q;
   logic [WW-1:0] word_reg_q;

   logic start2 = 1'b0;
   logic ready2 = 1'b1;
   logic frame_load2, frame_shift2, frame_bit2, word_shift2, word_bit2;
   logic word_valid2, word_last2, busy2, done2;
`ifdef SER_XFER_PARITY_EN
   logic word_parity2;
`endif
   logic [FW2-1:0] frame_data2 = '0;
   logic [FW2-1:0] frame_reg2_q;
   logic [WW-1:0]  word_reg2_q;

   exp_t sb[$];
   exp_t sb2[$];
   exp_t e_mon, e_mon2;

   int n_total = 0, n_bad = 0;
   int cyc = 0, start_cyc = 0, start_cyc2 = 0;
   int done_cnt = 0, done_cyc = 0, acc_cnt = 0;
   int done_cnt2 = 0, done_cyc2 = 0, acc_cnt2 = 0;
   bit pad_seen2 = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   serial_frame_unpacker u_dut (
      .clk(clk), .rst(rst), .start(start),
      .frame_load(frame_load), .frame_shift(frame_shift), .frame_bit(frame_bit),
      .word_shift(word_shift), .word_bit(word_bit), .word_valid(word_valid),
      .word_ready(word_ready), .word_last(word_last), .busy(busy),
`ifdef SER_XFER_PARITY_EN
      .word_parity(word_parity),
`endif
      .done(done)
   );

   serial_frame_unpacker #(.FRAME_W(FW2), .WORD_W(WW)) u_dut48 (
      .clk(clk), .rst(rst), .start(start2),
      .frame_load(frame_load2), .frame_shift(frame_shift2), .frame_bit(frame_bit2),
      .word_shift(word_shift2), .word_bit(word_bit2), .word_valid(word_valid2),
      .word_ready(ready2), .word_last(word_last2), .busy(busy2),
`ifdef SER_XFER_PARITY_EN
      .word_parity(word_parity2),
`endif
      .done(done2)
   );

   // Neighbouring shift registers: frame shifts out LSB-first, word fills from the top
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         frame_reg_q  <= '0;
         word_reg_q   <= '0;
         frame_reg2_q <= '0;
         word_reg2_q  <= '0;
      end else begin
         if (frame_load) frame_reg_q <= frame_data;
         else if (frame_shift) frame_reg_q <= frame_reg_q >> 1;
         if (word_shift) word_reg_q <= {word_bit, word_reg_q[WW-1:1]};
         if (frame_load2) frame_reg2_q <= frame_data2;
         else if (frame_shift2) frame_reg2_q <= frame_reg2_q >> 1;
         if (word_shift2) word_reg2_q <= {word_bit2, word_reg2_q[WW-1:1]};
      end
   end
   assign frame_bit  = frame_reg_q[0];
   assign frame_bit2 = frame_reg2_q[0];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end else begin
         $display("ok   %s got=%h", tag, got);
      end
   endtask

   always @(negedge clk) begin
      if (rst) begin
         if (word_valid && word_ready) begin
            if (sb.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
            else begin
               e_mon = sb.pop_front();
               chk("word", {8'd0, word_reg_q}, {8'd0, e_mon.w});
               chk("last", {31'd0, word_last}, {31'd0, e_mon.last});
`ifdef SER_XFER_PARITY_EN
               chk("parity", {31'd0, word_parity}, {31'd0, e_mon.par});
`endif
            end
            acc_cnt++;
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (word_valid2) begin
            if (sb2.size() == 0) chk("sb2_underflow", 32'd1, 32'd0);
            else begin
               e_mon2 = sb2.pop_front();
               chk("w48_word", {8'd0, word_reg2_q}, {8'd0, e_mon2.w});
               chk("w48_last", {31'd0, word_last2}, {31'd0, e_mon2.last});
            end
            acc_cnt2++;
         end
         if (word_shift2 && !frame_shift2) pad_seen2 = 1'b1;
         if (done2) begin
            done_cnt2++;
            done_cyc2 = cyc;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_frame(input logic [FW-1:0] f);
      exp_t e;
      for (int k = 0; k < NW; k++) begin
         e.w = '0;
         for (int j = 0; j < WW; j++)
            if (k * WW + j < FW) e.w[j] = f[k * WW + j];
         e.last = (k == NW - 1);
         e.par  = ^e.w;
         sb.push_back(e);
      end
   endtask

   task automatic start_frame(input logic [FW-1:0] f);
      frame_data = f;
      push_frame(f);
      start = 1'b1;
      tick();
      start = 1'b0;
      start_cyc = cyc;
   endtask

   task automatic wait_done(input string tag, input int exp_lat);
      int d0;
      d0 = done_cnt;
      for (int i = 0; i < 400 && done_cnt == d0; i++) tick();
      if (done_cnt == d0) chk({tag, "_timeout"}, 32'd1, 32'd0);
      else chk({tag, "_done_lat"}, done_cyc - start_cyc + 1, exp_lat);
      chk({tag, "_sb_left"}, sb.size(), 0);
      tick();
   endtask

   task automatic wait_acc(input int target);
      for (int i = 0; i < 400 && acc_cnt < target; i++) tick();
      if (acc_cnt < target) chk("acc_timeout", acc_cnt, target);
   endtask

   task automatic wait_valid();
      int i;
      i = 0;
      @(negedge clk);
      while (!word_valid && i < 400) begin
         @(negedge clk);
         i++;
      end
      if (!word_valid) chk("valid_timeout", 32'd0, 32'd1);
   endtask

   logic [WW-1:0] hold_w;
   logic          hold_l;
   int            d0, a0;

   initial begin
      #12;
      chk("rst_outs", {24'd0, frame_load, frame_shift, word_shift, word_bit,
                       word_valid, word_last, busy, done}, 32'd0);
      tick();
      rst = 1'b1;
      word_ready = 1'b1;
      tick();
      tick();

      // Basic frame, consumer always ready
      start_frame(80'h0123456789ABCDEF0123);
      @(negedge clk);
      chk("t1_load", {30'd0, frame_load, busy}, 32'd3);
      wait_valid();
      chk("t1_first_valid_lat", cyc - start_cyc + 1, 26);
      wait_done("t1", 102);

      // Stall the second word for five cycles
      a0 = acc_cnt;
      start_frame(80'h0123456789ABCDEF0123);
      wait_acc(a0 + 1);
      word_ready = 1'b0;
      wait_valid();
      hold_w = word_reg_q;
      hold_l = word_last;
      for (int i = 0; i < 5; i++) begin
         chk("t2_valid", {31'd0, word_valid}, 32'd1);
         chk("t2_word", {8'd0, word_reg_q}, {8'd0, hold_w});
         chk("t2_last", {31'd0, word_last}, {31'd0, hold_l});
         chk("t2_noshift", {30'd0, frame_shift, word_shift}, 32'd0);
         tick();
         if (i == 4) word_ready = 1'b1;
         else @(negedge clk);
      end
      wait_done("t2", 107);

      // Reset during the padding of the last word
      a0 = acc_cnt;
      start_frame(80'h0123456789ABCDEF0123);
      wait_acc(a0 + 3);
      for (int i = 0; i < 12; i++) tick();
      @(negedge clk);
      chk("t3_in_pad", {30'd0, frame_shift, word_shift}, 32'd1);
      d0 = done_cnt;
      #2;
      rst = 1'b0;
      sb.delete();
      #1;
      chk("t3_rst_outs", {24'd0, frame_load, frame_shift, word_shift, word_bit,
                          word_valid, word_last, busy, done}, 32'd0);
      tick();
      tick();
      chk("t3_rst_hold", {24'd0, frame_load, frame_shift, word_shift, word_bit,
                          word_valid, word_last, busy, done}, 32'd0);
      rst = 1'b1;
      tick();
      tick();
      chk("t3_no_done", done_cnt, d0);
      start_frame({FW{1'b1}});
      wait_done("t3_ones", 102);

      // start pulsed mid-transfer must be ignored
      a0 = acc_cnt;
      d0 = done_cnt;
      start_frame(80'hA5A5_5A5A_F00F_0FF0_1234);
      for (int i = 0; i < 10; i++) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done("t4", 102);
      for (int i = 0; i < 30; i++) tick();
      chk("t4_one_done", done_cnt, d0 + 1);
      chk("t4_words", acc_cnt - a0, NW);
      chk("t4_idle", {31'd0, busy}, 32'd0);

`ifdef SER_XFER_PARITY_EN
      start_frame(80'h1);
      wait_done("t6_par1", 102);
`endif

      // 48-bit frame: exact multiple of the word width, no padding
      frame_data2 = 48'h0123456789AB;
      sb2.push_back('{w: 24'h6789AB, last: 1'b0, par: 1'b0});
      sb2.push_back('{w: 24'h012345, last: 1'b1, par: 1'b0});
      d0 = done_cnt2;
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      start_cyc2 = cyc;
      for (int i = 0; i < 200 && done_cnt2 == d0; i++) tick();
      if (done_cnt2 == d0) chk("t5_timeout", 32'd1, 32'd0);
      else chk("t5_done_lat", done_cyc2 - start_cyc2 + 1, 52);
      chk("t5_words", acc_cnt2, 2);
      chk("t5_no_pad", {31'd0, pad_seen2}, 32'd0);
      chk("t5_sb_left", sb2.size(), 0);
      tick();
      chk("t5_idle", {31'd0, busy2}, 32'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
